// File: rtl/flex_stretch.sv
// rtl/flex_stretch.sv - pulse stretcher: each fast_enable event becomes a HIGH_CYCLES-wide slow_enable period
// Periods are separated by LOW_CYCLES low cycles; events arriving while busy are queued up to MAX_PENDING.
module flex_stretch #(
  parameter int HIGH_CYCLES = 8,
  parameter int LOW_CYCLES  = 1,
  parameter int MAX_PENDING = 3,
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          fast_enable,
  input  logic          clear,
  output logic          slow_enable,
  output logic          busy,
  output logic [PW-1:0] pending_count,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [7:0]    HI_LOAD = 8'(HIGH_CYCLES - 1);
  localparam logic [7:0]    LO_LOAD = 8'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PMAX    = PW'(MAX_PENDING);

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          slow_q, slow_d;
  logic          busy_q, busy_d;

  logic last_cycle;
  logic gap_end;
  logic dec;
  logic queue_evt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    last_cycle = (cnt_q == 8'd0);
    gap_end    = (state_q == GAP) && last_cycle;
    dec        = gap_end && (pend_q != '0);
    // An event in the final gap cycle with nothing queued launches the next period directly.
    queue_evt  = fast_enable && (state_q != IDLE) && !(gap_end && (pend_q == '0));

    case (state_q)
      IDLE: begin
        if (fast_enable) begin
          state_d = HIGH;
          cnt_d   = HI_LOAD;
        end
      end
      HIGH: begin
        if (last_cycle) begin
          state_d = GAP;
          cnt_d   = LO_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (last_cycle) begin
          if ((pend_q != '0) || fast_enable) begin
            state_d = HIGH;
            cnt_d   = HI_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    if (dec && !queue_evt) begin
      pend_d = pend_q - PW'(1);
    end else if (queue_evt && !dec) begin
      if (pend_q == PMAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PW'(1);
      end
    end

    if (clear) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      pend_d  = '0;
      ovf_d   = 1'b0;
    end

    slow_d = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      slow_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      slow_q  <= slow_d;
      busy_q  <= busy_d;
    end
  end

  assign slow_enable   = slow_q;
  assign busy          = busy_q;
  assign pending_count = pend_q;
  assign overflow      = ovf_q;

endmodule

// File: doc/flex_stretch.md
FLEX_STRETCH -- requirements
Module: flex_stretch

Interface
REQ-001 The block SHALL have parameter HIGH_CYCLES, default 8, setting the number of clk cycles slow_enable is held high per accepted pulse; legal range 1..255.
REQ-002 The block SHALL have parameter LOW_CYCLES, default 1, setting the minimum number of clk cycles slow_enable is held low between two high periods; legal range 1..255.
REQ-003 The block SHALL have parameter MAX_PENDING, default 3, setting the number of queued pulses held while busy; legal range 1..15.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 fast_enable  input  1  pulse request; each cycle sampled high counts as one event.
REQ-007 clear  input  1  synchronous abort and flush, active high.
REQ-008 slow_enable  output  1  registered stretched enable level.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 pending_count  output  PW  number of queued events, where PW = $clog2(MAX_PENDING+1).
REQ-011 overflow  output  1  sticky flag set when an event is dropped.

Function
REQ-012 The block SHALL implement the states IDLE, HIGH and GAP, encoded in a single state register.
REQ-013 In IDLE with fast_enable=1, the next state SHALL be HIGH and slow_enable SHALL be 1 from the next clk edge, giving one cycle of latency.
REQ-014 In HIGH, slow_enable SHALL stay 1 for exactly HIGH_CYCLES cycles, counted by a down-counter loaded on entry, and the state SHALL then go to GAP.
REQ-015 In GAP, slow_enable SHALL stay 0 for exactly LOW_CYCLES cycles.
REQ-016 At the end of GAP, if pending_count>0 the state SHALL go to HIGH and pending_count SHALL decrement; otherwise the state SHALL go to IDLE.
REQ-017 fast_enable=1 in HIGH or GAP SHALL increment pending_count, saturating at MAX_PENDING.
REQ-018 fast_enable=1 when pending_count==MAX_PENDING and no decrement occurs in the same cycle SHALL drop the event and set overflow to 1.
REQ-019 If fast_enable=1 in the final GAP cycle while pending_count>0, the increment and the decrement SHALL cancel, leaving pending_count unchanged, and overflow SHALL NOT be set.
REQ-020 fast_enable=1 in the final GAP cycle with pending_count==0 SHALL start a new HIGH directly, with no queueing.
REQ-021 With fast_enable held high N consecutive cycles, the block SHALL produce N high periods, subject to the MAX_PENDING limit.
REQ-022 Any two high periods SHALL always be separated by at least LOW_CYCLES low cycles, so a downstream rising-edge detector sees exactly one edge per period.
REQ-023 clear=1 SHALL force the next state to IDLE and SHALL zero slow_enable, pending_count, overflow and the cycle counter.
REQ-024 clear SHALL have priority over fast_enable; fast_enable in the same cycle as clear SHALL be ignored.
REQ-025 overflow SHALL be cleared only by clear or by reset.
REQ-026 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-027 While n_rst=0, the block SHALL hold state=IDLE, slow_enable=0, busy=0, pending_count=0, overflow=0 and the counter at 0, asynchronously.
REQ-028 Reset asserted mid-HIGH SHALL drop slow_enable to 0 immediately and discard all pending events.
REQ-029 After reset release, the first fast_enable SHALL behave as in IDLE.

Verification
REQ-030 Defaults, single pulse at cycle 10: slow_enable SHALL be high for cycles 11..18, low at 19, and busy SHALL fall at 20.
REQ-031 Defaults, pulses at cycles 10 and 12: slow_enable SHALL be high 11..18, low 19, high 20..27, with pending_count=1 during cycles 13..19.
REQ-032 Defaults, fast_enable held high for 6 cycles from cycle 10: pending_count SHALL saturate at 3, overflow SHALL be 1 from cycle 15, and exactly 4 high periods SHALL result.
REQ-033 Defaults, pulse in the last GAP cycle with pending_count=1: pending_count SHALL stay 1, overflow SHALL stay 0, and 3 high periods SHALL result in total.
REQ-034 clear asserted in cycle 14 during HIGH with pending_count=2 and fast_enable=1: in cycle 15 slow_enable, busy, pending_count and overflow SHALL all be 0.
REQ-035 n_rst pulsed low mid-HIGH, asynchronously between edges: slow_enable SHALL go to 0 without a clk edge, and the next pulse after release SHALL give a full 8-cycle high period.
